alu_mul_seq: RTL and testbench



---
 rtl/alu_mul_seq.sv | 150 +++++++++++++++
 tb/tb_alu_mul_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: computes the low WIDTH bits of a*b with shift-and-add on a
// shared Hack-style ALU. Each ADD or DBL cycle issues one ALU operation
// (x + y) and captures alu_out in that same cycle.
//
// Handshake: start is sampled only while the controller is idle (busy = 0).
// When start is accepted, a and b are captured. Later changes to a and b have
// no effect. done pulses for one cycle, and product/res_zr/res_ng are valid
// from that cycle on. They hold until the next operation completes. A start
// seen while busy, including the done cycle, is dropped.
module alu_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             res_zr,
  output logic             res_ng,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic             alu_zx,
  output logic             alu_nx,
  output logic             alu_zy,
  output logic             alu_ny,
  output logic             alu_f,
  output logic             alu_no,
  input  logic [WIDTH-1:0] alu_out,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DBL  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] acc, acc_n;
  logic [WIDTH-1:0] mc, mc_n;
  logic [WIDTH-1:0] mp, mp_n;

  // Step chosen from the remaining multiplier. When it reaches zero, the
  // controller stops without issuing any further ALU cycles.
  function automatic state_t route(input logic [WIDTH-1:0] m);
    if (m == '0)
      return DONE;
    else if (m[0])
      return ADD;
    else
      return DBL;
  endfunction

  // Only the add function is used, so the negate/zero controls stay low.
  assign alu_zx = 1'b0;
  assign alu_nx = 1'b0;
  assign alu_zy = 1'b0;
  assign alu_ny = 1'b0;
  assign alu_no = 1'b0;

  assign dbg_state = state;

  // Next-state and datapath update. The ALU result is consumed in the cycle it is produced.
  always_comb begin
    state_n = state;
    acc_n   = acc;
    mc_n    = mc;
    mp_n    = mp;
    case (state)
      IDLE: begin
        if (start) begin
          acc_n   = '0;
          mc_n    = a;
          mp_n    = b;
          state_n = route(b);
        end
      end
      ADD: begin
        acc_n   = alu_out;
        state_n = DBL;
      end
      DBL: begin
        mc_n    = alu_out;
        mp_n    = mp >> 1;
        state_n = route(mp >> 1);
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Register the state and all outputs. Outputs are computed from next-state
  // values, so ALU operands, busy, done and the result arrive with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      mc      <= '0;
      mp      <= '0;
      product <= '0;
      res_zr  <= 1'b1;
      res_ng  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      alu_x   <= '0;
      alu_y   <= '0;
      alu_f   <= 1'b0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      mc    <= mc_n;
      mp    <= mp_n;
      busy  <= (state_n != IDLE);
      done  <= (state_n == DONE);
      // acc is final on entry to DONE: the last step before DONE is a DBL,
      // or a zero multiplier, and neither changes acc.
      if (state_n == DONE) begin
        product <= acc_n;
        res_zr  <= (acc_n == '0);
        res_ng  <= acc_n[WIDTH-1];
      end
      case (state_n)
        ADD: begin
          alu_x <= acc_n;
          alu_y <= mc_n;
          alu_f <= 1'b1;
        end
        DBL: begin
          alu_x <= mc_n;
          alu_y <= mc_n;
          alu_f <= 1'b1;
        end
        default: begin
          alu_x <= '0;
          alu_y <= '0;
          alu_f <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Testbench for alu_mul_seq. Directed vectors with hand-computed products and
// done cycles. The driver pushes the expected result, and a monitor pops it
// and compares when done pulses.
module tb_alu_mul_seq;

  localparam int W = 16;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_DBL  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, res_zr, res_ng;
  logic [W-1:0] product;
  logic [W-1:0] alu_x, alu_y, alu_out;
  logic         alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
  logic [1:0]   dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  logic [1:0]   trace_q[$];
  logic         f_seen;

  alu_mul_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product),
    .res_zr(res_zr), .res_ng(res_ng),
    .alu_x(alu_x), .alu_y(alu_y),
    .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy), .alu_ny(alu_ny),
    .alu_f(alu_f), .alu_no(alu_no),
    .alu_out(alu_out), .dbg_state(dbg_state)
  );

  // Hack ALU reference: the combinational return path
  always_comb begin
    logic [W-1:0] xx, yy, oo;
    xx = alu_zx ? '0 : alu_x;
    if (alu_nx) xx = ~xx;
    yy = alu_zy ? '0 : alu_y;
    if (alu_ny) yy = ~yy;
    oo = alu_f ? (xx + yy) : (xx & yy);
    if (alu_no) oo = ~oo;
    alu_out = oo;
  end

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
      end else begin
        logic [W-1:0] ep;
        int           ec;
        ep = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        chk("product", 32'(product), 32'(ep));
        chk("res_zr", 32'(res_zr), 32'(ep == '0));
        chk("res_ng", 32'(res_ng), 32'(ep[W-1]));
        chk("done_cycle", 32'(cyc), 32'(ec));
      end
    end
  end

  // Issue one operation. lat is the cycle number (1-based) in which done is expected.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input int lat, input logic [W-1:0] ep, input bit push);
    @(negedge clk);
    start = 1'b1;
    a     = av;
    b     = bv;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    trace_q.delete();
    f_seen = 1'b0;
    if (push) begin
      exp_q.push_back(ep);
      exp_cyc_q.push_back(cyc + lat - 1);
    end
  endtask

  // Wait (bounded) for the controller to go idle, recording state and ALU activity
  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      trace_q.push_back(dbg_state);
      f_seen = f_seen | alu_f;
    end
    chk("idle_timeout", 32'(ok), 32'd1);
  endtask

  task automatic run(input logic [W-1:0] av, input logic [W-1:0] bv,
                     input int lat, input logic [W-1:0] ep);
    issue(av, bv, lat, ep, 1'b1);
    wait_idle();
  endtask

  initial begin
    logic [1:0] seq [6];
    seq = '{S_ADD, S_DBL, S_DBL, S_ADD, S_DBL, S_DONE};
    rst_n  = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    f_seen = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_product", 32'(product), 32'd0);
    chk("rst_res_zr", 32'(res_zr), 32'd1);
    chk("rst_res_ng", 32'(res_ng), 32'd0);
    chk("rst_alu_x", 32'(alu_x), 32'd0);
    chk("rst_alu_ctl", 32'({alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic product with state sequence check
    issue(16'd3, 16'd5, 6, 16'd15, 1'b1);
    chk("busy_rise", 32'(busy), 32'd1);
    wait_idle();
    chk("trace_len", 32'(trace_q.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      if (i < trace_q.size()) chk($sformatf("state_seq[%0d]", i), 32'(trace_q[i]), 32'(seq[i]));

    // Zero multiplier: no ALU cycles at all
    issue(16'h1234, 16'd0, 1, 16'd0, 1'b1);
    wait_idle();
    chk("zero_b_alu_f", 32'(f_seen), 32'd0);

    run(16'd300,  16'd300,  14, 16'h5F90);
    run(16'hFFFF, 16'hFFFF, 33, 16'h0001);
    run(16'hFFFE, 16'd3,    5,  16'hFFFA);
    run(16'd7,    16'd7,    7,  16'd49);
    run(16'd3,    16'h8000, 18, 16'h8000);
    run(16'h8000, 16'd2,    4,  16'h0000);
    chk("hold_product", 32'(product), 32'h0000);

    // Start while busy (cycle 3 of a 3*5 run) is ignored
    issue(16'd3, 16'd5, 6, 16'd15, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    a     = 16'd7;
    b     = 16'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();
    repeat (5) @(negedge clk);
    chk("ignored_start_busy", 32'(busy), 32'd0);
    chk("ignored_start_product", 32'(product), 32'd15);

    // Reset in cycle 2 aborts with no done
    issue(16'd3, 16'd5, 6, 16'd15, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_product", 32'(product), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_idle", 32'(busy), 32'd0);
    chk("pending_expectations", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
